// File: rtl/crossbar_scheduler.sv
// Crossbar scheduler for the 3-input / 3-output switch fabric.
// Parses the head byte of each input FIFO, arbitrates each output round-robin,
// pops the FIFOs and steers the output muxes for one packet at a time, and
// discards packets addressed to destination 0.
//
// Per-input FSM:
//   state | meaning
//   IDLE  | waiting for a header at the FIFO head
//   WAIT  | header parsed, requesting output dst
//   XFER  | granted; popping header + payload onto the output
//   DROP  | dest==0; popping header + payload without forwarding
module crossbar_scheduler #(
  parameter int LEN_W  = 6,
  parameter int DCNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        fifo_empty,
  input  logic [LEN_W+1:0]  fifo_q1,
  input  logic [LEN_W+1:0]  fifo_q2,
  input  logic [LEN_W+1:0]  fifo_q3,
  output logic [2:0]        rdreq,
  output logic [1:0]        sel1,
  output logic [1:0]        sel2,
  output logic [1:0]        sel3,
  output logic [2:0]        out_valid,
  output logic [DCNT_W-1:0] drop_count
);

  typedef enum logic [1:0] {IDLE, WAIT, XFER, DROP} state_t;

  localparam logic [LEN_W:0] REM_ONE = {{LEN_W{1'b0}}, 1'b1};

  state_t           st   [3];
  logic [LEN_W:0]   rem  [3];
  logic [1:0]       dst  [3];
  logic [1:0]       sel  [3];
  logic [1:0]       ptr  [3];
  logic [LEN_W+1:0] hdr  [3];
  logic [2:0]       cand [3];
  logic [2:0]       pick [3];
  logic [2:0]       grant;
  logic [2:0]       xpop;
  logic [2:0]       last;
  logic [2:0]       rel;
  logic [2:0]       hdr_drop;
  logic [1:0]       drop_inc;
  logic [DCNT_W:0]  dsum;

  assign hdr[0] = fifo_q1;
  assign hdr[1] = fifo_q2;
  assign hdr[2] = fifo_q3;
  assign sel1   = sel[0];
  assign sel2   = sel[1];
  assign sel3   = sel[2];

  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  // Returns {found, index} of the first requester at or after pointer p.
  function automatic logic [2:0] rr_pick(input logic [1:0] p, input logic [2:0] c);
    logic [1:0] i;
    logic [2:0] r;
    r = 3'b000;
    i = p;
    for (int k = 0; k < 3; k++) begin
      if (!r[2] && c[i]) r = {1'b1, i};
      i = inc3(i);
    end
    return r;
  endfunction

  // Pops, output valids, releases, arbitration and drop detection for this cycle.
  always_comb begin
    rdreq     = '0;
    xpop      = '0;
    last      = '0;
    out_valid = '0;
    rel       = '0;
    grant     = '0;
    hdr_drop  = '0;
    drop_inc  = '0;
    for (int i = 0; i < 3; i++) begin
      rdreq[i]    = (st[i] == XFER || st[i] == DROP) && !fifo_empty[i];
      xpop[i]     = (st[i] == XFER) && !fifo_empty[i];
      last[i]     = xpop[i] && (rem[i] == REM_ONE);
      hdr_drop[i] = (st[i] == IDLE) && !fifo_empty[i] && (hdr[i][1:0] == 2'd0);
      drop_inc    = drop_inc + {1'b0, hdr_drop[i]};
    end
    for (int j = 0; j < 3; j++) begin
      cand[j] = '0;
      for (int i = 0; i < 3; i++) begin
        cand[j][i] = (sel[j] == 2'd0) && (st[i] == WAIT) && (dst[i] == 2'(j + 1));
        if (sel[j] == 2'(i + 1)) begin
          out_valid[j] = xpop[i];
          rel[j]       = last[i];
        end
      end
      pick[j] = rr_pick(ptr[j], cand[j]);
      if (pick[j][2]) grant[pick[j][1:0]] = 1'b1;
    end
    dsum = {1'b0, drop_count} + {{(DCNT_W-1){1'b0}}, drop_inc};
  end

  // Input FSMs, output grant/select registers, RR pointers and drop counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        st[i]  <= IDLE;
        rem[i] <= '0;
        dst[i] <= '0;
        sel[i] <= '0;
        ptr[i] <= '0;
      end
      drop_count <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        case (st[i])
          IDLE: if (!fifo_empty[i]) begin
            dst[i] <= hdr[i][1:0];
            rem[i] <= {1'b0, hdr[i][LEN_W+1:2]} + REM_ONE;
            st[i]  <= (hdr[i][1:0] == 2'd0) ? DROP : WAIT;
          end
          WAIT: if (grant[i]) st[i] <= XFER;
          XFER, DROP: if (!fifo_empty[i]) begin
            rem[i] <= rem[i] - REM_ONE;
            if (rem[i] == REM_ONE) st[i] <= IDLE;
          end
          default: st[i] <= IDLE;
        endcase
      end
      for (int j = 0; j < 3; j++) begin
        if (pick[j][2]) begin
          sel[j] <= pick[j][1:0] + 2'd1;
          ptr[j] <= inc3(pick[j][1:0]);
        end else if (rel[j]) begin
          sel[j] <= 2'd0;
        end
      end
      drop_count <= dsum[DCNT_W] ? '1 : dsum[DCNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_crossbar_scheduler.sv
// Bench for crossbar_scheduler: directed timing scenarios plus a randomized
// run checked by a byte-level routing scoreboard fed from FIFO models.
module tb_crossbar_scheduler;
  localparam int HN = 8192;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] fifo_empty;
  logic [7:0] fifo_q1, fifo_q2, fifo_q3;
  logic [2:0] rdreq, out_valid;
  logic [1:0] sel1, sel2, sel3;
  logic [7:0] drop_count;
  logic [1:0] sel_a [3];

  crossbar_scheduler #(.LEN_W(6), .DCNT_W(8)) dut (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty),
    .fifo_q1(fifo_q1), .fifo_q2(fifo_q2), .fifo_q3(fifo_q3),
    .rdreq(rdreq), .sel1(sel1), .sel2(sel2), .sel3(sel3),
    .out_valid(out_valid), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  assign sel_a[0] = sel1;
  assign sel_a[1] = sel2;
  assign sel_a[2] = sel3;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  logic [7:0] fq [3][$];
  logic [1:0] route_q [3][$];
  logic [2:0] rd_prev = '0;
  logic [2:0] stall_mask = '0;
  logic       rnd_stall = 1'b0;
  logic       sb_on = 1'b0;
  logic [2:0] ov_h [HN];
  logic [2:0] rd_h [HN];
  logic [1:0] sel_h [HN][3];
  logic [7:0] dc_h [HN];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_past(input int c);
    while (cyc <= c) tick();
  endtask

  task automatic push_pkt(input int i, input int dest, input int len);
    fq[i].push_back(8'((len << 2) | dest));
    route_q[i].push_back(2'(dest));
    for (int b = 0; b < len; b++) begin
      fq[i].push_back(8'($urandom));
      route_q[i].push_back(2'(dest));
    end
  endtask

  function automatic int pending();
    return fq[0].size() + fq[1].size() + fq[2].size();
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    stall_mask = '0;
    rnd_stall = 1'b0;
    sb_on = 1'b0;
    for (int i = 0; i < 3; i++) begin
      fq[i].delete();
      route_q[i].delete();
    end
    tick();
    @(negedge clk);
    chk("rst_rdreq", 32'(rdreq), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_sel", 32'({sel1, sel2, sel3}), 0);
    chk("rst_drop_count", 32'(drop_count), 0);
    tick();
    reset = 1'b1;
  endtask

  // FIFO models: pop on last cycle's rdreq, then present the head (optionally stalled).
  initial begin
    logic [2:0] e;
    fifo_empty = 3'b111;
    fifo_q1 = '0; fifo_q2 = '0; fifo_q3 = '0;
    forever begin
      @(posedge clk);
      for (int i = 0; i < 3; i++)
        if (rd_prev[i] && fq[i].size() > 0) void'(fq[i].pop_front());
      #2;
      for (int i = 0; i < 3; i++)
        e[i] = (fq[i].size() == 0) || stall_mask[i] || (rnd_stall && $urandom_range(0, 4) == 0);
      fifo_empty = e;
      fifo_q1 = (fq[0].size() > 0) ? fq[0][0] : 8'h00;
      fifo_q2 = (fq[1].size() > 0) ? fq[1][0] : 8'h00;
      fifo_q3 = (fq[2].size() > 0) ? fq[2][0] : 8'h00;
    end
  end

  // Per-cycle logging, invariants and routing scoreboard.
  initial begin
    int k, r;
    forever begin
      @(negedge clk);
      rd_prev = rdreq;
      if (cyc < HN) begin
        ov_h[cyc] = out_valid;
        rd_h[cyc] = rdreq;
        for (int j = 0; j < 3; j++) sel_h[cyc][j] = sel_a[j];
        dc_h[cyc] = drop_count;
      end
      chk("pop_when_empty", 32'(rdreq & fifo_empty), 0);
      for (int j = 0; j < 3; j++)
        if (out_valid[j]) begin
          k = int'(sel_a[j]);
          chk("valid_has_source", (k != 0) ? 32'(rdreq[k-1]) : 0, 1);
        end
      if (sb_on)
        for (int i = 0; i < 3; i++)
          if (rdreq[i]) begin
            r = 0;
            for (int j = 0; j < 3; j++)
              if (out_valid[j] && int'(sel_a[j]) == i + 1) r = j + 1;
            if (route_q[i].size() == 0) chk("sb_extra_pop", 1, 0);
            else chk("sb_route", r, 32'(route_q[i].pop_front()));
          end
      cyc++;
    end
  end

  initial begin
    int t0, n, n_drop;
    int exp2_sel [8]  = '{0, 0, 1, 1, 0, 3, 3, 0};
    int exp2_ov  [8]  = '{0, 0, 1, 1, 0, 1, 1, 0};
    int exp3_sel [14] = '{0, 0, 1, 1, 0, 3, 3, 0, 1, 1, 0, 3, 3, 0};

    // 1: single packet FIFO1 -> output 2
    do_reset();
    push_pkt(0, 2, 2);
    t0 = cyc;
    wait_past(t0 + 5);
    chk("t1_ov_before", 32'(ov_h[t0+1]), 0);
    for (int c = t0 + 2; c <= t0 + 4; c++) begin
      chk("t1_ov2", 32'(ov_h[c][1]), 1);
      chk("t1_sel2", 32'(sel_h[c][1]), 1);
      chk("t1_rd1", 32'(rd_h[c][0]), 1);
    end
    chk("t1_ov_after", 32'(ov_h[t0+5]), 0);
    chk("t1_sel2_after", 32'(sel_h[t0+5][1]), 0);

    // 2: FIFO1 and FIFO3 contend for output 1
    do_reset();
    push_pkt(0, 1, 1);
    push_pkt(2, 1, 1);
    t0 = cyc;
    wait_past(t0 + 7);
    for (int c = 0; c < 8; c++) begin
      chk("t2_sel1", 32'(sel_h[t0+c][0]), exp2_sel[c]);
      chk("t2_ov1", 32'(ov_h[t0+c][0]), exp2_ov[c]);
    end

    // 3: both re-request; grants alternate 1,3,1,3
    do_reset();
    push_pkt(0, 1, 1); push_pkt(0, 1, 1);
    push_pkt(2, 1, 1); push_pkt(2, 1, 1);
    t0 = cyc;
    wait_past(t0 + 13);
    for (int c = 0; c < 14; c++) chk("t3_sel1", 32'(sel_h[t0+c][0]), exp3_sel[c]);

    // 3b: pointer after FIFO2's grant favours FIFO3 over FIFO1
    do_reset();
    push_pkt(1, 1, 3);
    t0 = cyc;
    tick();
    push_pkt(0, 1, 1);
    push_pkt(2, 1, 1);
    wait_past(t0 + 10);
    chk("t3b_sel1_first", 32'(sel_h[t0+7][0]), 3);
    chk("t3b_sel1_second", 32'(sel_h[t0+10][0]), 1);

    // 4: concurrent FIFO1->3 and FIFO2->1
    do_reset();
    push_pkt(0, 3, 4);
    push_pkt(1, 1, 4);
    t0 = cyc;
    wait_past(t0 + 7);
    for (int c = t0 + 2; c <= t0 + 6; c++) begin
      chk("t4_ov", 32'(ov_h[c]), 3'b101);
      chk("t4_rd", 32'(rd_h[c]), 3'b011);
      chk("t4_sel3", 32'(sel_h[c][2]), 1);
      chk("t4_sel1", 32'(sel_h[c][0]), 2);
    end
    chk("t4_ov_end", 32'(ov_h[t0+7]), 0);

    // 5: dropped packet, then saturation of the drop counter
    do_reset();
    push_pkt(0, 0, 3);
    t0 = cyc;
    wait_past(t0 + 6);
    n = 0;
    for (int c = t0; c <= t0 + 6; c++) begin
      n += int'(rd_h[c][0]);
      chk("t5_no_valid", 32'(ov_h[c]), 0);
    end
    chk("t5_pops", n, 4);
    chk("t5_dc_before", 32'(dc_h[t0]), 0);
    chk("t5_dc_after", 32'(dc_h[t0+1]), 1);
    for (int p = 0; p < 300; p++) push_pkt(p % 3, 0, 0);
    for (int w = 0; w < 3000 && pending() != 0; w++) tick();
    chk("t5_drain", pending(), 0);
    tick(); tick();
    chk("t5_saturated", 32'(drop_count), 255);

    // 6: stall mid-packet, then reset mid-transfer
    do_reset();
    push_pkt(0, 2, 6);
    t0 = cyc;
    wait_past(t0 + 3);
    stall_mask = 3'b001;
    wait_past(t0 + 8);
    stall_mask = 3'b000;
    wait_past(t0 + 14);
    n = 0;
    for (int c = t0 + 4; c <= t0 + 8; c++) begin
      chk("t6_stall_rd", 32'(rd_h[c][0]), 0);
      chk("t6_stall_ov", 32'(ov_h[c]), 0);
      chk("t6_stall_sel", 32'(sel_h[c][1]), 1);
    end
    for (int c = t0; c <= t0 + 14; c++) n += int'(rd_h[c][0]);
    chk("t6_pops", n, 7);
    chk("t6_last_valid", 32'(ov_h[t0+13][1]), 1);
    chk("t6_sel_release", 32'(sel_h[t0+14][1]), 0);

    do_reset();
    push_pkt(0, 1, 10);
    t0 = cyc;
    wait_past(t0 + 3);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    wait_past(t0 + 5);
    chk("t6_rst_rd", 32'(rd_h[t0+5]), 0);
    chk("t6_rst_ov", 32'(ov_h[t0+5]), 0);
    chk("t6_rst_sel", 32'({sel_h[t0+5][0], sel_h[t0+5][1], sel_h[t0+5][2]}), 0);

    // Random traffic with stalls against the routing scoreboard
    do_reset();
    n_drop = 0;
    for (int p = 0; p < 15; p++)
      for (int i = 0; i < 3; i++) begin
        int d, l;
        d = $urandom_range(0, 3);
        l = $urandom_range(0, 7);
        if (d == 0) n_drop++;
        push_pkt(i, d, l);
      end
    sb_on = 1'b1;
    rnd_stall = 1'b1;
    for (int w = 0; w < 5000 && pending() != 0; w++) tick();
    chk("rnd_drain", pending(), 0);
    tick(); tick();
    chk("rnd_sb_left", route_q[0].size() + route_q[1].size() + route_q[2].size(), 0);
    chk("rnd_drop_count", 32'(drop_count), n_drop);
    chk("rnd_idle_valid", 32'(out_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
